// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder owning a word array, with wait states and error checks
// Optional request/error counters: define DATA_MEM_RESP_STATS_EN.
module data_mem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DATA_MEM_RESP_STATS_EN
  ,
  output logic [31:0] stat_reqs,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [MEM_WORDS];

  logic        accept, do_access, do_write;
  logic        err, misaligned, illegal, out_of_range;
  logic [AW-1:0] idx;
  logic [31:0] word, shifted, load_data, wd;
  logic [3:0]  be;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
      else if (state == S_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd0) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    accept    = req_valid && req_ready;
    do_access = (state == S_ACCESS);
    do_write  = do_access && we_q && !err;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  // Stores may only use B/H/W; the unsigned codes are load-only.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (f3_q)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr_q[0];
      3'b010:         misaligned = (addr_q[1:0] != 2'b00);
      default:        illegal    = 1'b1;
    endcase
    if (we_q && f3_q[2]) illegal = 1'b1;
    out_of_range = ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));
    err = misaligned || illegal || out_of_range;
  end

  always_comb begin
    idx     = addr_q[AW+1:2];
    word    = mem[idx];
    shifted = word >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase
  end

  // Array is deliberately left out of reset; a reset edge also suppresses a pending write.
  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
      rsp_err   <= err;
    end
  end

`ifdef DATA_MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_reqs <= 32'd0;
      stat_errs <= 16'd0;
    end else begin
      if (accept && stat_reqs != '1) stat_reqs <= stat_reqs + 32'd1;
      if (rsp_valid && rsp_ready && rsp_err && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks of data_mem_responder against a byte-level model
module tb_data_mem_responder;
  localparam int MEM_WORDS   = 1024;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DATA_MEM_RESP_STATS_EN
  logic [31:0] stat_reqs;
  logic [15:0] stat_errs;
`endif

  int errors = 0;
  int checks = 0;
  int exp_reqs = 0;
  int exp_errs = 0;
  logic [7:0] model [4*MEM_WORDS];

  data_mem_responder #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DATA_MEM_RESP_STATS_EN
    , .stat_reqs(stat_reqs), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: byte-addressed little-endian memory, sizes from the width code.
  function automatic void ref_access(input logic we, input logic [31:0] a, input logic [2:0] f3,
                                     input logic [31:0] wdv, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    rd = 32'd0;
    er = 1'b0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (we && f3 >= 3'd4)) er = 1'b1;
    else if ((a % size) != 0) er = 1'b1;
    else if ((a / 4) >= MEM_WORDS) er = 1'b1;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) model[int'(a) + i] = wdv[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(model[int'(a) + i]) << (8*i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endfunction

  // Runs one full transaction from IDLE; also returns the model's expectation.
  task automatic txn(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wdv,
                     output logic [31:0] rd, output logic er, output int lat,
                     output logic [31:0] exp_rd, output logic exp_er);
    ref_access(we, a, f3, wdv, exp_rd, exp_er);
    req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wdv; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_reqs++;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (exp_er) exp_errs++;
    if (rsp_valid === 1'b1) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
`ifdef DATA_MEM_RESP_STATS_EN
    checks++; if (stat_reqs !== 32'd0) begin errors++; $display("FAIL reset_stat_reqs: got %0d want 0", stat_reqs); end
`endif
    reset = 1'b1;
    exp_reqs = 0;
    exp_errs = 0;
  endtask

  task automatic test_word();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat, erd, eer);
    checks++; if (lat != WAIT_CYCLES + 1) begin errors++; $display("FAIL sw_latency: got %0d want %0d", lat, WAIT_CYCLES + 1); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b want 0/0", rd, er); end
    txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat, erd, eer);
    checks++; if (lat != WAIT_CYCLES + 1) begin errors++; $display("FAIL lw_latency: got %0d want %0d", lat, WAIT_CYCLES + 1); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data: got %h/%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1'b1, 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    txn(1'b1, 32'h13, 3'b000, 32'h80, rd, er, lat, erd, eer);
    txn(1'b0, 32'h13, 3'b000, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb_sign: got %h/%b want ffffff80/0", rd, er); end
    txn(1'b0, 32'h13, 3'b100, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h00000080 || er !== 1'b0) begin errors++; $display("FAIL lbu_zero: got %h/%b want 00000080/0", rd, er); end
    txn(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL sb_lane: got %h want 80000000", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1'b0, 32'h11, 3'b001, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lh_misaligned: got %h/%b want 0/1", rd, er); end
    txn(1'b1, 32'h12, 3'b010, 32'h12345678, rd, er, lat, erd, eer);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_misaligned: got err %b want 1", er); end
    txn(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL sw_err_nowrite: got %h want 80000000", rd); end
    txn(1'b0, 32'(4*MEM_WORDS), 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lw_range: got %h/%b want 0/1", rd, er); end
    txn(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat, erd, eer);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_f3: got err %b want 1", er); end
    txn(1'b1, 32'h10, 3'b100, 32'hFF, rd, er, lat, erd, eer);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_unsigned: got err %b want 1", er); end
    txn(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL sbu_nowrite: got %h want 80000000", rd); end
`ifdef DATA_MEM_RESP_STATS_EN
    checks++; if (stat_errs !== 16'(exp_errs)) begin errors++; $display("FAIL stat_errs: got %0d want %0d", stat_errs, exp_errs); end
    checks++; if (stat_reqs !== 32'(exp_reqs)) begin errors++; $display("FAIL stat_reqs: got %0d want %0d", stat_reqs, exp_reqs); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1'b1, 32'h10, 3'b010, 32'hCAFEF00D, rd, er, lat, erd, eer);
    ref_access(1'b0, 32'h10, 3'b010, 32'h0, erd, eer);
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_reqs++;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: rsp_valid %b want 1", rsp_valid); end
    req_we = 1'b1; req_wdata = 32'h0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b rdata=%h err=%b want 1/0/cafef00d/0",
                 c, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    txn(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_ignored_req: got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1'b1, 32'h20, 3'b010, 32'h11223344, rd, er, lat, erd, eer);
    req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_reqs = 0;
    exp_errs = 0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_state: ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    txn(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL midop_nowrite: got %h/%b want 11223344/0", rd, er); end
`ifdef DATA_MEM_RESP_STATS_EN
    checks++; if (stat_reqs !== 32'(exp_reqs)) begin errors++; $display("FAIL midop_stat_reqs: got %0d want %0d", stat_reqs, exp_reqs); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wdv; logic er, eer, we; logic [2:0] f3; int lat;
    for (int w = 0; w < 16; w++) txn(1'b1, 32'(4*w), 3'b010, $urandom, rd, er, lat, erd, eer);
    for (int n = 0; n < 150; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      wdv = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'(4*MEM_WORDS) + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 63));
      txn(we, a, f3, wdv, rd, er, lat, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat != WAIT_CYCLES + 1) begin
        errors++;
        $display("FAIL rand %0d we=%b f3=%0d addr=%h: got %h/%b lat %0d want %h/%b lat %0d",
                 n, we, f3, a, rd, er, lat, erd, eer, WAIT_CYCLES + 1);
      end
    end
`ifdef DATA_MEM_RESP_STATS_EN
    checks++; if (stat_errs !== 16'(exp_errs)) begin errors++; $display("FAIL rand_stat_errs: got %0d want %0d", stat_errs, exp_errs); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
